// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants: default widths and result bus field layout.
// The reservation station decodes its snoop bus with the same definitions.
package wb_arbiter_pkg;

    localparam int PREG_W_DEF = 6;
    localparam int ROB_W_DEF  = 6;
    localparam int DATA_W     = 32;
    localparam int NUM_FU_DEF = 3;

    localparam int BUS_WIDTH     = 1 + ROB_W_DEF + PREG_W_DEF + DATA_W;
    localparam int BUS_VALID     = 44;
    localparam int BUS_ROB_HI    = 43;
    localparam int BUS_ROB_LO    = 38;
    localparam int BUS_RD_HI     = 37;
    localparam int BUS_RD_LO     = 32;
    localparam int BUS_RESULT_HI = 31;
    localparam int BUS_RESULT_LO = 0;

    // Add an offset to a round-robin index, wrapping modulo 3.
    function automatic logic [1:0] rr_add(
        input logic [1:0] p,
        input logic [1:0] o
    );
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, o};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-FU result buffer: small power-of-2 FIFO with registered count.
// Head is the oldest entry; push is refused when full, pop when empty.
module wb_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: buffers FU results and broadcasts up to two per cycle.
// Round-robin scan from rr_ptr picks bus0 then bus1 from distinct FIFOs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int PREG_WIDTH = PREG_W_DEF,
    parameter int ROB_WIDTH  = ROB_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_FU     = NUM_FU_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  logic [NUM_FU*PREG_WIDTH-1:0]        fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]            fu_result,
    input  logic [NUM_FU*ROB_WIDTH-1:0]         fu_rob,
    output logic [NUM_FU-1:0]                   fu_ready,
    output logic [ROB_WIDTH+PREG_WIDTH+DATA_W:0] bus0,
    output logic [ROB_WIDTH+PREG_WIDTH+DATA_W:0] bus1,
    output logic                                idle
);

    localparam int ENTRY_W = ROB_WIDTH + PREG_WIDTH + DATA_W;
    localparam int BW      = ENTRY_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  full;
    logic [NUM_FU-1:0]  empty;
    logic [ENTRY_W-1:0] head  [NUM_FU];
    logic [CNT_W-1:0]   count [NUM_FU];

    logic [1:0]    rr_ptr;
    logic [1:0]    rr_next;
    logic [1:0]    g0;
    logic [1:0]    g1;
    logic          g0_vld;
    logic          g1_vld;
    logic [BW-1:0] bus0_d;
    logic [BW-1:0] bus1_d;
    logic          all_zero;

    assign fu_ready = rst_n ? ~full : '0;
    assign push     = fu_valid & fu_ready;

    for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   ({fu_rob[k*ROB_WIDTH +: ROB_WIDTH],
                     fu_rd[k*PREG_WIDTH +: PREG_WIDTH],
                     fu_result[k*DATA_W +: DATA_W]}),
            .full  (full[k]),
            .empty (empty[k]),
            .count (count[k]),
            .head  (head[k])
        );
    end

    // Scan from rr_ptr: first non-empty FIFO to bus0, second to bus1.
    always_comb begin
        logic [1:0] idx;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0     = '0;
        g1     = '0;
        idx    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = rr_add(rr_ptr, 2'(i));
            if (!empty[idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0     = idx;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1     = idx;
                end
            end
        end
    end

    // Pops, next pointer (after last grant) and next bus words.
    always_comb begin
        pop     = '0;
        rr_next = rr_ptr;
        bus0_d  = '0;
        bus1_d  = '0;
        if (g0_vld) begin
            pop[g0] = 1'b1;
            bus0_d  = {1'b1, head[g0]};
            rr_next = rr_add(g0, 2'd1);
        end
        if (g1_vld) begin
            pop[g1] = 1'b1;
            bus1_d  = {1'b1, head[g1]};
            rr_next = rr_add(g1, 2'd1);
        end
    end

    // Arbitration pointer and registered result buses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            bus0   <= '0;
            bus1   <= '0;
        end else begin
            rr_ptr <= rr_next;
            bus0   <= bus0_d;
            bus1   <= bus1_d;
        end
    end

    // Idle when nothing is buffered and nothing is on either bus.
    always_comb begin
        all_zero = 1'b1;
        for (int k = 0; k < NUM_FU; k++) begin
            if (count[k] != '0) begin
                all_zero = 1'b0;
            end
        end
        idle = all_zero && !bus0[BW-1] && !bus1[BW-1];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, contention, backpressure.
// Streaming phase tracks accepted pushes in a per-FU ordered scoreboard.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  fu_valid;
    logic [17:0] fu_rd;
    logic [95:0] fu_result;
    logic [17:0] fu_rob;
    logic [2:0]  fu_ready;
    logic [44:0] bus0;
    logic [44:0] bus1;
    logic        idle;

    int n_cmp = 0;
    int n_bad = 0;

    logic [44:0] q [$];
    int          last [3];

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fu_valid  (fu_valid),
        .fu_rd     (fu_rd),
        .fu_result (fu_result),
        .fu_rob    (fu_rob),
        .fu_ready  (fu_ready),
        .bus0      (bus0),
        .bus1      (bus1),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [44:0] bw(logic [5:0] rob, logic [5:0] rd,
                                       logic [31:0] res);
        return {1'b1, rob, rd, res};
    endfunction

    function automatic logic [44:0] sw(int k, int s);
        return bw(6'(k * 8 + s), 6'(s + 1), {8'(k), 24'(s)});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(int k, logic [44:0] w);
        fu_rob[k*6 +: 6]     = w[43:38];
        fu_rd[k*6 +: 6]      = w[37:32];
        fu_result[k*32 +: 32] = w[31:0];
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fu_valid = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic bus_check(string tag, logic [44:0] b, int n);
        int found;
        found = -1;
        if (b[44]) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i][31:24] == b[31:24]) begin
                    found = i;
                    break;
                end
            end
            if (found >= 0) begin
                chk(tag, b, q[found]);
                q.delete(found);
            end else begin
                chk(tag, b, 45'h0);
            end
            if (b[31:24] < 8'd3) begin
                last[b[25:24]] = n;
            end
        end
    endtask

    task automatic stream(int n_edges, bit long_run);
        int         seq [3];
        logic [2:0] acc;
        for (int k = 0; k < 3; k++) begin
            seq[k]  = 0;
            last[k] = 1;
            set_fu(k, sw(k, 0));
        end
        fu_valid = 3'b111;
        acc      = fu_ready & fu_valid;
        for (int n = 1; n <= n_edges; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) begin
                    q.push_back(sw(k, seq[k]));
                    seq[k]++;
                    set_fu(k, sw(k, seq[k]));
                end
            end
            bus_check("s_bus0", bus0, n);
            bus_check("s_bus1", bus1, n);
            if (bus0[44] && bus1[44]) begin
                chk("s_distinct", 64'(bus0[31:24] == bus1[31:24]), 64'd0);
            end
            if (long_run) begin
                if (n >= 3) begin
                    for (int k = 0; k < 3; k++) begin
                        chk("s_fair", 64'((n - last[k]) <= 2), 64'd1);
                    end
                end
                case (n)
                    8:  chk("s_rdy8",  fu_ready, 3'b011);
                    9:  chk("s_rdy9",  fu_ready, 3'b101);
                    10: chk("s_rdy10", fu_ready, 3'b110);
                    11: chk("s_rdy11", fu_ready, 3'b011);
                    default: ;
                endcase
            end
            acc = fu_ready & fu_valid;
        end
        if (long_run) begin
            fu_valid = 3'b000;
            for (int i = 0; i < 20; i++) begin
                tick();
                bus_check("d_bus0", bus0, 100);
                bus_check("d_bus1", bus1, 100);
                if (idle) break;
            end
            chk("drain_q", 64'(q.size()), 64'd0);
            chk("drain_idle", idle, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        fu_valid  = 3'b000;
        fu_rd     = '0;
        fu_result = '0;
        fu_rob    = '0;

        // Reset behaviour
        repeat (3) tick();
        chk("rst_ready", fu_ready, 3'b000);
        chk("rst_bus0", bus0, 45'h0);
        chk("rst_bus1", bus1, 45'h0);
        chk("rst_idle", idle, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", fu_ready, 3'b111);
        chk("rel_idle", idle, 1'b1);

        // Single result from FU1
        set_fu(1, bw(6'd9, 6'd5, 32'hDEADBEEF));
        fu_valid = 3'b010;
        tick();
        fu_valid = 3'b000;
        chk("one_lat", bus0[44], 1'b0);
        chk("one_busy", idle, 1'b0);
        tick();
        chk("one_bus0", bus0, bw(6'd9, 6'd5, 32'hDEADBEEF));
        chk("one_bus1", bus1, 45'h0);
        tick();
        chk("one_b0z", bus0, 45'h0);
        chk("one_b1z", bus1, 45'h0);
        chk("one_idle", idle, 1'b1);

        // Three-way contention from rr_ptr = 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_fu(k, bw(6'(k + 10), 6'(k + 1), 32'hA0 + k));
        end
        fu_valid = 3'b111;
        tick();
        fu_valid = 3'b000;
        tick();
        chk("c3_bus0a", bus0, bw(6'd10, 6'd1, 32'hA0));
        chk("c3_bus1a", bus1, bw(6'd11, 6'd2, 32'hA1));
        tick();
        chk("c3_bus0b", bus0, bw(6'd12, 6'd3, 32'hA2));
        chk("c3_bus1b", bus1, 45'h0);
        tick();
        chk("c3_idle", idle, 1'b1);

        // Continuous streaming with backpressure, then drain
        do_reset();
        q.delete();
        stream(12, 1'b1);

        // Reset asserted with two entries per FIFO
        do_reset();
        q.delete();
        stream(4, 1'b0);
        rst_n    = 1'b0;
        fu_valid = 3'b000;
        #1;
        chk("mr_bus0", bus0, 45'h0);
        chk("mr_bus1", bus1, 45'h0);
        chk("mr_ready", fu_ready, 3'b000);
        chk("mr_idle", idle, 1'b1);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_quiet", {bus0[44], bus1[44]}, 2'b00);
        end
        set_fu(2, bw(6'd3, 6'd7, 32'h12345678));
        fu_valid = 3'b100;
        tick();
        fu_valid = 3'b000;
        tick();
        chk("mr_new0", bus0, bw(6'd3, 6'd7, 32'h12345678));
        chk("mr_new1", bus1, 45'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Completion/writeback stage at the far end of the issue path.
- Accepts results from the three functional units (FU0, FU1 = ALUs; FU2 = load/store) and buffers them in one small FIFO per FU.
- Each cycle, broadcasts up to two results on the two result buses (bus0, bus1), which the reservation station snoops at negedge and the ROB consumes for completion.
- Round-robin arbitration keeps any one FU from starving the others.

Parameters:
- PREG_WIDTH, 6, physical register tag width.
- ROB_WIDTH, 6, ROB index width.
- FIFO_DEPTH, 4, entries per FU result FIFO (power of 2, ≥2).
- NUM_FU, 3, number of FU result ports (fixed at 3; parameter is documentation only).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fu_valid  in  3  bit k: FU k presents a result this cycle.
- fu_rd  in  3*PREG_WIDTH  dest phys reg; FU k at [k*PREG_WIDTH +: PREG_WIDTH].
- fu_result  in  96  result data; FU k at [k*32 +: 32].
- fu_rob  in  3*ROB_WIDTH  ROB index; FU k at [k*ROB_WIDTH +: ROB_WIDTH].
- fu_ready  out  3  bit k: FIFO k can accept this cycle.
- bus0  out  BUS_WIDTH  result bus 0 (registered).
- bus1  out  BUS_WIDTH  result bus 1 (registered).
- idle  out  1  all FIFOs empty and both buses invalid.

Behaviour:
- Bus format, BUS_WIDTH = 1+ROB_WIDTH+PREG_WIDTH+32 = 45:
  - [44] BUS_VALID
  - [43:38] BUS_ROB
  - [37:32] BUS_RD
  - [31:0] BUS_RESULT
- Reset (rst_n low, async):
  - All FIFO counts/pointers cleared; rr_ptr = 0.
  - bus0 = bus1 = 0 (valid low).
  - fu_ready = 3'b000 while rst_n is low; 3'b111 on the first cycle after release.
  - idle = 1.
- Push:
  - fu_ready[k] = (count_k < FIFO_DEPTH), from registered count only; no same-cycle pop bypass.
  - A push occurs on posedge when fu_valid[k] && fu_ready[k].
  - fu_valid with fu_ready low is ignored; the FU must hold and retry.
- Candidates: FIFOs non-empty at the start of the cycle. A result pushed at edge N is first eligible at edge N+1, so it appears on a bus after edge N+1 (min latency 2 edges from presentation).
- Arbitration (combinational, registered into the buses):
  - Scan order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - First non-empty FIFO goes to bus0; second goes to bus1.
  - Granted FIFOs pop at the same edge.
- rr_ptr update: becomes (index of last granted FIFO + 1) mod 3; unchanged if no grant.
- Bus with no grant: whole word driven to 0 (valid low, no stale fields).
- One FIFO never supplies both buses in the same cycle, even with 2+ entries.
- Same-cycle push and pop on one FIFO: count unchanged, data order preserved (FIFO ordering per FU).
- Full FIFO popped this cycle: fu_ready stays low this cycle, goes high next cycle.
- rd == 0: broadcast normally; the ROB still needs completion. Filtering is the consumer's job.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- idle: combinational, (all counts == 0) && !bus0[44] && !bus1[44].
- Reset asserted mid-operation: buffered results are discarded. Flush and recovery are the ROB's responsibility.

Decomposition:
- Shared constants file (alongside existing constants.v): BUS_WIDTH, BUS_VALID, BUS_ROB, BUS_RD, BUS_RESULT field ranges. This extends the existing bus fields with BUS_ROB; the reservation station is updated to the same definitions.
- Sub-module wb_fifo (one per FU, width ROB_WIDTH+PREG_WIDTH+32, depth FIFO_DEPTH):
  - Ports: push/pop/full/empty/count/head.
  - Async active-low reset.
- Top holds the arbiter, rr_ptr and bus registers.

Test Plan:
- Reset: hold rst_n low 3 cycles, then release -> fu_ready=000 during reset, 111 after; bus0/bus1=0; idle=1.
- Single result: FU1 pushes rd=5, rob=9, result=0xDEADBEEF at edge N -> bus0 = {1, 9, 5, 0xDEADBEEF} after edge N+1; bus1 valid=0; next cycle both buses 0 and idle=1.
- Three-way contention: all FUs push once at edge N, rr_ptr=0 -> edge N+1: bus0=FU0, bus1=FU1, rr_ptr becomes 2; edge N+2: bus0=FU2, bus1 invalid.
- Backpressure: FU2 pushes every cycle while FU0/FU1 stream continuously -> fu_ready[2] drops after 4 outstanding; no FU2 entry is lost or reordered; every FU gets ≥1 grant per 2 cycles.
- Full plus simultaneous pop: fill FIFO0 to 4, hold fu_valid[0] high -> fu_ready[0]=0 on the popping cycle, 1 the cycle after; the stalled result is accepted exactly once.
- Reset mid-stream: assert rst_n with 2 entries in each FIFO -> buses go to 0 immediately; after release no stale result is ever broadcast.
